// File: rtl/xadc_multi_ch_reader.sv
// ---------------------------------------------------------------------------
// xadc_multi_ch_reader
// DRP read sequencer for the XADC wizard. When an end-of-conversion arrives
// for a channel inside the aux window [CH_BASE, CH_BASE+NUM_CH-1], it issues
// one DRP read. It optionally averages 2^AVG_LOG2 samples per channel. It
// publishes the latest 12-bit result per channel plus a streaming strobe.
//
// Ports
//   clk, rst_n      : system clock (also XADC dclk), async active-low reset
//   eoc, channel    : XADC end-of-conversion pulse and its channel code
//   drp_den/daddr   : DRP read request (one-cycle enable, 7-bit address)
//   drp_dwe, drp_di : tied to 0, the block only reads
//   drp_drdy/do     : DRP read response
//   sample*         : averaged result, channel index, 1-cycle valid strobe
//   sample_bus      : latest result per channel, channel i at [12i+11:12i]
//   overrun         : in-range eoc dropped because a read was in flight
//   timeout_err     : drp_drdy not seen within TIMEOUT cycles
// ---------------------------------------------------------------------------
module xadc_multi_ch_reader #(
   parameter int unsigned NUM_CH   = 4,
   parameter logic [4:0]  CH_BASE  = 5'h16,
   parameter int unsigned AVG_LOG2 = 0,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    eoc,
   input  logic [4:0]              channel,
   output logic                    drp_den,
   output logic [6:0]              drp_daddr,
   output logic                    drp_dwe,
   output logic [15:0]             drp_di,
   input  logic                    drp_drdy,
   input  logic [15:0]             drp_do,
   output logic [11:0]             sample,
   output logic [3:0]              sample_ch,
   output logic                    sample_valid,
   output logic [12*NUM_CH-1:0]    sample_bus,
   output logic                    overrun,
   output logic                    timeout_err
);

   localparam int unsigned ACC_W = 12 + AVG_LOG2;
   localparam int unsigned CNT_W = AVG_LOG2 + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [5:0]       RANGE_LO = 6'(CH_BASE);
   localparam logic [5:0]       RANGE_HI = 6'(CH_BASE) + 6'(NUM_CH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [TMO_W-1:0]     tmo_cnt;
   logic [ACC_W-1:0]     acc [NUM_CH];
   logic [CNT_W-1:0]     cnt [NUM_CH];

   logic                 in_range_c;
   logic [IDX_W-1:0]     ch_idx_c;
   logic [11:0]          code_c;
   logic [ACC_W-1:0]     acc_sum_c;
   logic                 unused_low_bits_c;

   assign drp_dwe = 1'b0;
   assign drp_di  = 16'h0000;

   // Low nibble of the DRP word is below the 12-bit ADC resolution.
   assign unused_low_bits_c = ^drp_do[3:0];

   // Window decode done 6 bits wide so CH_BASE+NUM_CH cannot wrap.
   always_comb begin
      in_range_c = ({1'b0, channel} >= RANGE_LO) && ({1'b0, channel} < RANGE_HI);
      ch_idx_c   = IDX_W'(channel - CH_BASE);
      code_c     = drp_do[15:4];
      acc_sum_c  = acc[idx] + ACC_W'(code_c);
   end

   // Sequencer: IDLE -> ISSUE (den next cycle) -> WAIT (drdy or timeout).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         idx          <= '0;
         tmo_cnt      <= '0;
         drp_den      <= 1'b0;
         drp_daddr    <= '0;
         sample       <= '0;
         sample_ch    <= '0;
         sample_valid <= 1'b0;
         sample_bus   <= '0;
         overrun      <= 1'b0;
         timeout_err  <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         drp_den      <= 1'b0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         timeout_err  <= 1'b0;

         if (eoc && in_range_c && (state != S_IDLE)) begin
            overrun <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (eoc && in_range_c) begin
                  idx       <= ch_idx_c;
                  drp_daddr <= {2'b00, channel};
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               drp_den <= 1'b1;
               tmo_cnt <= TMO_W'(TIMEOUT);
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (drp_drdy) begin
                  // Last sample of the window: publish the mean and restart.
                  if (cnt[idx] == CNT_LAST) begin
                     sample                 <= 12'(acc_sum_c >> AVG_LOG2);
                     sample_ch              <= 4'(idx);
                     sample_valid           <= 1'b1;
                     sample_bus[12*idx +: 12] <= 12'(acc_sum_c >> AVG_LOG2);
                     acc[idx]               <= '0;
                     cnt[idx]               <= '0;
                  end else begin
                     acc[idx] <= acc_sum_c;
                     cnt[idx] <= cnt[idx] + CNT_W'(1);
                  end
                  state <= S_IDLE;
               end else if (tmo_cnt <= TMO_W'(1)) begin
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - TMO_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xadc_multi_ch_reader.sv
// ---------------------------------------------------------------------------
// tb_xadc_multi_ch_reader
// Scoreboard bench: the driver issues eoc/DRP traffic and pushes expected
// averaged samples from a per-channel running-sum model; a monitor pops and
// compares on every sample_valid.
// ---------------------------------------------------------------------------
module tb_xadc_multi_ch_reader;

   localparam int unsigned NUM_CH   = 4;
   localparam logic [4:0]  CH_BASE  = 5'h16;
   localparam int unsigned AVG_LOG2 = 2;
   localparam int unsigned TIMEOUT  = 64;
   localparam int          NAVG     = 1 << AVG_LOG2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 eoc;
   logic [4:0]           channel;
   logic                 drp_den;
   logic [6:0]           drp_daddr;
   logic                 drp_dwe;
   logic [15:0]          drp_di;
   logic                 drp_drdy;
   logic [15:0]          drp_do;
   logic [11:0]          sample;
   logic [3:0]           sample_ch;
   logic                 sample_valid;
   logic [12*NUM_CH-1:0] sample_bus;
   logic                 overrun;
   logic                 timeout_err;

   xadc_multi_ch_reader #(
      .NUM_CH(NUM_CH), .CH_BASE(CH_BASE), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .eoc(eoc), .channel(channel),
      .drp_den(drp_den), .drp_daddr(drp_daddr), .drp_dwe(drp_dwe), .drp_di(drp_di),
      .drp_drdy(drp_drdy), .drp_do(drp_do),
      .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
      .sample_bus(sample_bus), .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   // Reference model: running sum and count per channel.
   typedef struct { int val; int ch; } exp_t;
   exp_t        q[$];
   int          exp_sum [NUM_CH];
   int          exp_n   [NUM_CH];
   logic [11:0] exp_bus [NUM_CH];

   function automatic void model_clear();
      for (int i = 0; i < NUM_CH; i++) begin
         exp_sum[i] = 0; exp_n[i] = 0; exp_bus[i] = '0;
      end
      q.delete();
   endfunction

   function automatic void model_read(input int i, input int code);
      exp_t e;
      exp_sum[i] += code;
      exp_n[i]++;
      if (exp_n[i] == NAVG) begin
         e.val = exp_sum[i] / NAVG;
         e.ch  = i;
         q.push_back(e);
         exp_sum[i] = 0;
         exp_n[i]   = 0;
      end
   endfunction

   function automatic logic [12*NUM_CH-1:0] model_bus();
      logic [12*NUM_CH-1:0] b;
      for (int i = 0; i < NUM_CH; i++) b[12*i +: 12] = exp_bus[i];
      return b;
   endfunction

   // Monitor: pulse counters plus scoreboard compare on sample_valid.
   int   den_cnt = 0, ovr_cnt = 0, tmo_cnt = 0, den_consec = 0;
   logic prev_den = 1'b0;
   exp_t mon_e;

   always @(negedge clk) begin
      if (drp_den && prev_den) den_consec++;
      prev_den = drp_den;
      if (drp_den)     den_cnt++;
      if (overrun)     ovr_cnt++;
      if (timeout_err) tmo_cnt++;
      if (sample_valid) begin
         if (q.size() == 0) begin
            check("unexpected_valid", 64'(1), 64'(0));
         end else begin
            mon_e = q.pop_front();
            check("sample", 64'(sample), 64'(mon_e.val));
            check("sample_ch", 64'(sample_ch), 64'(mon_e.ch));
            exp_bus[mon_e.ch] = 12'(mon_e.val);
            check("sample_bus", 64'(sample_bus), 64'(model_bus()));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // One eoc and, for in-range channels, the DRP handshake around it.
   task automatic do_read(input logic [4:0] ch, input logic [11:0] code,
                          input int dly, input bit withhold, input bit ovr);
      bit inr;
      int d0, o0, t0, n, dl;
      inr = (int'(ch) >= int'(CH_BASE)) && (int'(ch) < int'(CH_BASE) + NUM_CH);
      d0 = den_cnt; o0 = ovr_cnt; t0 = tmo_cnt; dl = dly;
      eoc = 1'b1; channel = ch;
      tick();
      eoc = 1'b0; channel = 5'($urandom);
      tick();
      if (!inr) begin
         check("oor_den", 64'(drp_den), 64'(0));
         repeat (4) tick();
         check("oor_den_cnt", 64'(den_cnt - d0), 64'(0));
         check("oor_overrun", 64'(ovr_cnt - o0), 64'(0));
         return;
      end
      check("den_latency", 64'(drp_den), 64'(1));
      check("daddr", 64'(drp_daddr), 64'({2'b00, ch}));
      if (ovr) begin
         eoc = 1'b1; channel = CH_BASE + 5'($urandom_range(0, NUM_CH - 1));
         tick();
         eoc = 1'b0;
         if (dl > 0) dl--;
      end
      if (withhold) begin
         n = 0;
         while (!timeout_err && n < int'(TIMEOUT) + 8) begin
            tick(); n++;
         end
         check("timeout_latency", 64'(n), 64'(TIMEOUT));
         tick();
         check("timeout_pulses", 64'(tmo_cnt - t0), 64'(1));
      end else begin
         repeat (dl) tick();
         drp_drdy = 1'b1; drp_do = {code, 4'($urandom)};
         model_read(int'(ch - CH_BASE), int'(code));
         tick();
         drp_drdy = 1'b0; drp_do = 16'($urandom);
      end
      check("den_pulses", 64'(den_cnt - d0), 64'(1));
      check("overrun_pulses", 64'(ovr_cnt - o0), 64'(ovr));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] ch;
      int r;
      model_clear();
      rst_n = 1'b0; eoc = 1'b0; channel = '0; drp_drdy = 1'b0; drp_do = '0;
      #12;
      check("rst_den", 64'(drp_den), 64'(0));
      check("rst_daddr", 64'(drp_daddr), 64'(0));
      check("rst_sample", 64'({sample, sample_ch, sample_valid}), 64'(0));
      check("rst_bus", 64'(sample_bus), 64'(0));
      check("rst_flags", 64'({overrun, timeout_err}), 64'(0));
      check("dwe_di", 64'({drp_dwe, drp_di}), 64'(0));
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Four-sample average: 407 >> 2 = 101 on index 0 only after the 4th read.
      do_read(5'h16, 12'd100, 3, 0, 0);
      do_read(5'h16, 12'd101, 1, 0, 0);
      do_read(5'h16, 12'd102, 0, 0, 0);
      do_read(5'h16, 12'd104, 2, 0, 0);
      check("avg_valid", 64'(sample_valid), 64'(1));
      check("avg_value", 64'(sample), 64'(101));
      check("avg_ch", 64'(sample_ch), 64'(0));
      tick();

      // Out-of-range channel, overrun during WAIT, timeout then recovery.
      do_read(5'h03, 12'hFFF, 0, 0, 0);
      do_read(5'h17, 12'hABC, 3, 0, 1);
      do_read(5'h18, 12'h123, 0, 1, 0);
      do_read(5'h18, 12'h456, 2, 0, 0);

      // Reset during WAIT with two samples accumulated on index 3.
      do_read(5'h19, 12'd900, 1, 0, 0);
      do_read(5'h19, 12'd901, 1, 0, 0);
      eoc = 1'b1; channel = 5'h19;
      tick();
      eoc = 1'b0;
      tick();
      check("rstmid_den_before", 64'(drp_den), 64'(1));
      rst_n = 1'b0;
      #1;
      check("rstmid_den", 64'(drp_den), 64'(0));
      check("rstmid_outs", 64'({sample, sample_ch, sample_valid, overrun, timeout_err}), 64'(0));
      check("rstmid_bus", 64'(sample_bus), 64'(0));
      model_clear();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      // Stray drdy with nothing issued must be ignored.
      drp_drdy = 1'b1; drp_do = 16'hFFF0;
      tick();
      drp_drdy = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) do_read(5'h19, 12'(200 + 3 * i), i, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            ch = 5'($urandom_range(0, 21));
            if ($urandom_range(0, 1) == 1) ch = 5'($urandom_range(26, 31));
         end else begin
            ch = CH_BASE + 5'($urandom_range(0, NUM_CH - 1));
         end
         do_read(ch, 12'($urandom), $urandom_range(0, 10), (i == 30), (r == 1));
      end

      repeat (3) tick();
      check("queue_empty", 64'(q.size()), 64'(0));
      check("den_consecutive", 64'(den_consec), 64'(0));
      check("final_bus", 64'(sample_bus), 64'(model_bus()));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/xadc_multi_ch_reader.md
Name: xadc_multi_ch_reader

Overview:
Parametrised DRP read sequencer for the XADC wizard IP, replacing the single-channel, fixed-address hookup on aux 6. It sits between the xadc_wiz_0 DRP/EOC ports and user logic. On each end-of-conversion for a channel in a configurable aux window, it issues one DRP read and optionally averages 2^AVG_LOG2 samples per channel. It publishes the latest 12-bit result per channel, plus a streaming valid strobe.

Parameters:
NUM_CH, 4, number of consecutive aux channels serviced (1..16)
CH_BASE, 5'h16, XADC channel code of the first serviced channel (aux n = 5'h10+n; 5'h16 = aux 6)
AVG_LOG2, 0, log2 of the samples averaged per output (0..6; 0 = no averaging)
TIMEOUT, 64, clk cycles to wait for drp_drdy before abandoning a read (>=4)

Ports:
clk  in  1  100 MHz system clock, also drives XADC dclk_in
rst_n  in  1  asynchronous active-low reset
eoc  in  1  XADC eoc_out, 1-cycle pulse
channel  in  5  XADC channel_out, valid while eoc is high
drp_den  out  1  DRP enable to den_in
drp_daddr  out  7  DRP address to daddr_in
drp_dwe  out  1  constant 0 (read-only)
drp_di  out  16  constant 0
drp_drdy  in  1  XADC drdy_out
drp_do  in  16  XADC do_out
sample  out  12  averaged result; code = drp_do[15:4]
sample_ch  out  4  index (0..NUM_CH-1) for sample
sample_valid  out  1  1-cycle strobe; sample and sample_ch are valid
sample_bus  out  12*NUM_CH  latest result per channel; channel i at bits [12i+11:12i]
overrun  out  1  1-cycle pulse: in-range eoc arrived while not IDLE, sample dropped
timeout_err  out  1  1-cycle pulse: drp_drdy not seen within TIMEOUT cycles

Behaviour:
- Reset (async assert, sync release) clears the following to 0:
  - FSM state to IDLE
  - outputs drp_den, drp_daddr, sample, sample_ch, sample_valid, sample_bus, overrun, timeout_err
  - all accumulators and per-channel sample counters
- In-range test: CH_BASE <= channel <= CH_BASE+NUM_CH-1. Index = channel - CH_BASE.
- An out-of-range eoc is ignored silently in every state.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: on eoc && in-range, latch the index, set drp_daddr = {2'b00, channel}, go to ISSUE.
  - ISSUE: drp_den = 1 for exactly this cycle; load the timeout counter with TIMEOUT; go to WAIT.
  - WAIT: on drp_drdy, capture drp_do[15:4], perform the accumulate step, go to IDLE.
  - WAIT: if the counter reaches 0 without drdy, pulse timeout_err, discard the read, go to IDLE.
  - WAIT: a drp_drdy arriving outside WAIT is ignored.
- drp_den is never high in two consecutive cycles. It is never reasserted before drdy or a timeout ends the read.
- In-range eoc in ISSUE or WAIT: overrun pulses the next cycle; the sample is dropped; the in-flight read is unaffected.
- Accumulate step for channel i, with acc width 12+AVG_LOG2 and cnt width AVG_LOG2+1:
  - acc[i] += code; cnt[i] += 1.
  - When cnt[i] reaches 2^AVG_LOG2, the next cycle does all of:
    - sample = acc[i] >> AVG_LOG2 (truncate, no rounding)
    - sample_ch = i
    - sample_valid = 1
    - sample_bus slice i = the same value
    - acc[i] and cnt[i] cleared
  - AVG_LOG2 = 0: every read produces an output.
  - Accumulators cannot overflow by construction.
- Latency, with eoc sampled high at cycle 0:
  - drp_den high at cycle 2 (IDLE->ISSUE transition at edge 1).
  - drdy at cycle k gives sample_valid at cycle k+1.
  - The next eoc is accepted from cycle k+1.
- Other channels' accumulators persist across reads and timeouts.
- A timeout does not advance cnt.
- Reset mid-read: the FSM returns to IDLE, partial averages are lost, and drp_den drops immediately.
- A drdy after reset release with no issued read is ignored.

Test Plan:
- NUM_CH=4, CH_BASE=5'h16, AVG_LOG2=0. eoc with channel=5'h17; drp_do=16'hABC0 returned 3 cycles after den -> exactly one den pulse with drp_daddr=7'h17; sample=12'hABC, sample_ch=1, sample_valid 1 cycle; sample_bus[23:12]=12'hABC.
- AVG_LOG2=2, four reads on channel 5'h16 with codes 100,101,102,104 -> only the 4th read yields sample_valid; sample=101 (407>>2); no strobe on reads 1-3.
- eoc on channel 5'h03 (out of range) -> no den, no overrun, outputs unchanged.
- Second in-range eoc while in WAIT -> overrun pulses once; only one den pulse; the first read completes normally.
- drdy withheld for TIMEOUT=64 cycles -> timeout_err pulses 1 cycle; no sample_valid; a subsequent eoc is serviced normally.
- rst_n low during WAIT with AVG_LOG2=2 and 2 samples accumulated -> all outputs 0 asynchronously. After release, 4 fresh reads are needed before sample_valid.
